// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: opcodes, FSM states and decode helpers shared by the seq_alu_n block
package seq_alu_pkg;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b1000;
    typedef enum logic [2:0] {IDLE, ADDSUB, MUL, DIV, FIN} state_t;
    function automatic logic is_onehot4(input logic [3:0] v);
        return v != 4'b0 && (v & (v - 4'd1)) == 4'b0;
    endfunction
    function automatic state_t first_state(input logic [3:0] o, input logic b_zero);
        return !is_onehot4(o) ? FIN :
               (o == OP_ADD || o == OP_SUB) ? ADDSUB :
               o == OP_MUL ? MUL :
               b_zero ? FIN : DIV;
    endfunction
endpackage

// File: rtl/seq_alu_divider.sv
// seq_alu_divider: restoring divider, one quotient bit per step, MSB first
module seq_alu_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem
);
    logic [WIDTH:0] trial;
    logic           fits;
    assign trial = {rem, quo[WIDTH-1]};
    assign fits  = trial >= {1'b0, b};
    // quo doubles as the dividend shift register; rem stays below b so WIDTH bits suffice
    always_ff @(posedge clk) begin
        if (rst) begin
            quo <= '0;
            rem <= '0;
        end else if (load) begin
            quo <= a;
            rem <= '0;
        end else if (step) begin
            rem <= fits ? WIDTH'(trial - {1'b0, b}) : trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], fits};
        end
    end
endmodule

// File: rtl/seq_alu_n.sv
// seq_alu_n: start/busy/done ALU (add, sub, shift-add mul, restoring div); SEQ_ALU_PENDING_EN adds a one-entry request slot
module seq_alu_n
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] result,
    output logic [WIDTH-1:0]   remainder,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               req_drop
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    state_t             state, nstate;
    logic [WIDTH-1:0]   a_r, b_r, la, lb, quo, prem, mplier;
    logic [3:0]         op_r, lop;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc, mcand, fin_res;
    logic [WIDTH-1:0]   fin_rem;
    logic [WIDTH:0]     sum, diff;
    logic               launch, drop, last, div0, illegal;
    assign busy    = state != IDLE;
    assign last    = cnt == CNT_W'(WIDTH);
    assign sum     = {1'b0, a_r} + {1'b0, b_r};
    assign diff    = {1'b0, a_r} - {1'b0, b_r};
    assign illegal = !is_onehot4(op_r);
    assign div0    = op_r == OP_DIV && b_r == '0;
    assign fin_res = illegal ? '0 : div0 ? '1 : op_r == OP_DIV ? {{WIDTH{1'b0}}, quo} : acc;
    assign fin_rem = illegal ? '0 : div0 ? a_r : op_r == OP_DIV ? prem : '0;
`ifdef SEQ_ALU_PENDING_EN
    logic             pend_v, pend_load;
    logic [WIDTH-1:0] pend_a, pend_b;
    logic [3:0]       pend_op;
    // launch source selection: pending slot first, then a start arriving in FIN or IDLE
    always_comb begin
        launch    = start && (state == IDLE || state == FIN);
        la        = a;
        lb        = b;
        lop       = op;
        if (state == FIN && pend_v) begin
            launch = 1'b1;
            la     = pend_a;
            lb     = pend_b;
            lop    = pend_op;
        end
        pend_load = start && busy && (state == FIN ? pend_v : !pend_v);
        drop      = start && busy && state != FIN && pend_v;
    end
    // one-entry slot; refilled in FIN when its previous content launches
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_v  <= 1'b0;
            pend_a  <= '0;
            pend_b  <= '0;
            pend_op <= '0;
        end else if (pend_load) begin
            pend_v  <= 1'b1;
            pend_a  <= a;
            pend_b  <= b;
            pend_op <= op;
        end else if (state == FIN) begin
            pend_v  <= 1'b0;
        end
    end
`else
    // launch only from IDLE; any start while busy is dropped
    always_comb begin
        launch = start && state == IDLE;
        la     = a;
        lb     = b;
        lop    = op;
        drop   = start && busy;
    end
`endif
    // next-state: launch decodes the first state, iterative states exit once the counter hits WIDTH
    always_comb begin
        nstate = state;
        if (launch)
            nstate = first_state(lop, lb == '0);
        else if (state == ADDSUB || ((state == MUL || state == DIV) && last))
            nstate = FIN;
        else if (state == FIN)
            nstate = IDLE;
    end
    // state, operand capture, shift-add multiplier and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_r       <= '0;
            b_r       <= '0;
            op_r      <= '0;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            result    <= '0;
            remainder <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            req_drop  <= 1'b0;
        end else begin
            state    <= nstate;
            done     <= state == FIN;
            req_drop <= drop;
            if (launch) begin
                a_r    <= la;
                b_r    <= lb;
                op_r   <= lop;
                cnt    <= '0;
                acc    <= '0;
                mcand  <= {{WIDTH{1'b0}}, la};
                mplier <= lb;
            end else if (state == MUL && !last) begin
                cnt    <= cnt + CNT_W'(1);
                acc    <= acc + (mplier[0] ? mcand : '0);
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
            end else if (state == DIV && !last) begin
                cnt    <= cnt + CNT_W'(1);
            end else if (state == ADDSUB) begin
                acc    <= op_r == OP_ADD ? {{(WIDTH-1){1'b0}}, sum} : {{(WIDTH-1){diff[WIDTH]}}, diff};
            end
            if (state == FIN) begin
                result    <= fin_res;
                remainder <= fin_rem;
                err       <= div0 || illegal;
            end
        end
    end
    seq_alu_divider #(.WIDTH(WIDTH)) u_div (
        .clk  (clk),
        .rst  (rst),
        .load (launch),
        .step (state == DIV && !last),
        .a    (la),
        .b    (b_r),
        .quo  (quo),
        .rem  (prem)
    );
endmodule
